// File: rtl/t07_spi_reg_bank.sv
// t07_spi_reg_bank: SPI-filled register bank with doorbell lock and read handshake
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   spi_wr_en_i       SPI write strobe (one write per cycle)
//   spi_addr_i        SPI write address
//   spi_wdata_i       SPI write data
//   rd_req_i          core read request (level); a rising edge is one accept
//   rd_addr_i         core read address, sampled on the accept cycle
//   rd_data_o         registered read data, held until the next accept
//   rd_ack_o          one-cycle acknowledge, the cycle after an accept
//   bank_ready_o      high while the bank is frozen (LOCKED)
//   overrun_o         sticky: an SPI write was dropped while LOCKED
//   clr_overrun_i     clears overrun_o and drop_cnt_o (a same-cycle drop wins)
//   drop_cnt_o        saturating count of dropped SPI writes
module t07_spi_reg_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_wr_en_i,
    input  logic [ADDR_W-1:0] spi_addr_i,
    input  logic [DATA_W-1:0] spi_wdata_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_ack_o,
    output logic              bank_ready_o,
    output logic              overrun_o,
    input  logic              clr_overrun_i,
    output logic [CNT_W-1:0]  drop_cnt_o
);
    typedef enum logic {FILL, LOCKED} state_e;

    localparam logic [ADDR_W-1:0] DOORBELL = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              req_q, rd_ack_q, overrun_q, overrun_d;
    logic              accept, wr, drop, locked;

    always_comb begin
        locked     = state_q == LOCKED;
        accept     = rd_req_i & ~req_q;
        wr         = spi_wr_en_i & ~locked;
        drop       = spi_wr_en_i & locked;
        state_d    = state_q;
        if (wr && spi_addr_i == DOORBELL) state_d = LOCKED;
        // reading the doorbell hands the bank back to the SPI side
        if (locked && accept && rd_addr_i == DOORBELL) state_d = FILL;
        rd_data_d  = accept ? (locked ? regs_q[rd_addr_i] : '0) : rd_data_q;
        overrun_d  = drop | (overrun_q & ~clr_overrun_i);
        // a drop coinciding with a clear restarts the count at one
        drop_cnt_d = drop ? (clr_overrun_i ? CNT_W'(1) :
                             (&drop_cnt_q ? drop_cnt_q : drop_cnt_q + CNT_W'(1))) :
                     clr_overrun_i ? '0 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            req_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_ack_q   <= 1'b0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= rd_req_i;
            rd_data_q  <= rd_data_d;
            rd_ack_q   <= accept;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
            if (wr) regs_q[spi_addr_i] <= spi_wdata_i;
        end
    end

    assign rd_data_o    = rd_data_q;
    assign rd_ack_o     = rd_ack_q;
    assign bank_ready_o = state_q == LOCKED;
    assign overrun_o    = overrun_q;
    assign drop_cnt_o   = drop_cnt_q;
endmodule

// File: tb/tb_t07_spi_reg_bank.sv
// tb_t07_spi_reg_bank: scoreboard bench for the default bank and a 16x8 variant
module tb_t07_spi_reg_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0, rq = 1'b0, clr = 1'b0;
    logic [4:0]  wa = '0, ra = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd_data;
    logic        rd_ack, ready, ovr;
    logic [7:0]  cnt;

    logic        wr_b = 1'b0, rq_b = 1'b0;
    logic [2:0]  wa_b = '0, ra_b = '0;
    logic [15:0] wd_b = '0;
    logic [15:0] rd_data_b;
    logic        rd_ack_b, ready_b, ovr_b;
    logic [7:0]  cnt_b;

    int n_tests = 0, n_fail = 0, acks = 0;
    logic [31:0] q[$];
    logic [15:0] qb[$];

    logic [31:0] mem [32];
    logic        locked_m = 1'b0, req_m = 1'b0, ovr_m = 1'b0;
    logic [7:0]  cnt_m = '0;

    always #5 clk = ~clk;

    t07_spi_reg_bank dut (
        .clk(clk), .rst(rst), .spi_wr_en_i(wr), .spi_addr_i(wa), .spi_wdata_i(wd),
        .rd_req_i(rq), .rd_addr_i(ra), .rd_data_o(rd_data), .rd_ack_o(rd_ack),
        .bank_ready_o(ready), .overrun_o(ovr), .clr_overrun_i(clr), .drop_cnt_o(cnt)
    );

    t07_spi_reg_bank #(.DATA_W(16), .DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .spi_wr_en_i(wr_b), .spi_addr_i(wa_b), .spi_wdata_i(wd_b),
        .rd_req_i(rq_b), .rd_addr_i(ra_b), .rd_data_o(rd_data_b), .rd_ack_o(rd_ack_b),
        .bank_ready_o(ready_b), .overrun_o(ovr_b), .clr_overrun_i(1'b0), .drop_cnt_o(cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rd_ack) begin
            acks++;
            if (q.size() == 0) check("spurious_ack", 1, 0);
            else check("rd_data", rd_data, q.pop_front());
        end
        if (!rst && rd_ack_b) begin
            if (qb.size() == 0) check("spurious_ack_b", 1, 0);
            else check("rd_data_b", rd_data_b, qb.pop_front());
        end
    end

    task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic r, input logic [4:0] b, input logic c);
        logic acc, nxt;
        wr = w; wa = a; wd = d; rq = r; ra = b; clr = c;
        acc = r && !req_m;
        if (acc) q.push_back(locked_m ? mem[b] : 32'h0);
        nxt = locked_m;
        if (w && !locked_m && a == 5'd31) nxt = 1'b1;
        if (acc && locked_m && b == 5'd31) nxt = 1'b0;
        if (w && !locked_m) mem[a] = d;
        if (w && locked_m) begin
            ovr_m = 1'b1;
            cnt_m = c ? 8'd1 : (cnt_m == 8'hff ? cnt_m : cnt_m + 8'd1);
        end else if (c) begin
            ovr_m = 1'b0;
            cnt_m = 8'd0;
        end
        req_m = r;
        locked_m = nxt;
        @(posedge clk); #1;
        check("bank_ready", ready, locked_m);
        check("overrun", ovr, ovr_m);
        check("drop_cnt", cnt, cnt_m);
    endtask

    task automatic spi(input logic [4:0] a, input logic [31:0] d);
        step(1, a, d, 0, 0, 0);
    endtask

    task automatic rd(input logic [4:0] a);
        step(0, 0, 0, 1, a, 0);
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic step_b(input logic w, input logic [2:0] a, input logic [15:0] d,
                          input logic r, input logic [2:0] b);
        wr_b = w; wa_b = a; wd_b = d; rq_b = r; ra_b = b;
        @(posedge clk); #1;
        wr_b = 1'b0; rq_b = 1'b0;
    endtask

    initial begin
        int a0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_ack", rd_ack, 0);
        check("rst_ready", ready, 0);
        check("rst_overrun", ovr, 0);
        check("rst_drop_cnt", cnt, 0);
        check("rst_ready_b", ready_b, 0);

        rd(3);
        spi(5, 32'hDEADBEEF);
        spi(2, 32'h2222);
        spi(31, 32'h1);
        check("ready_after_doorbell", ready, 1);
        rd(5);
        rd(31);
        check("ready_after_release", ready, 0);

        spi(31, 32'h2);
        for (int i = 0; i < 300; i++) spi(2, i);
        check("overrun_sat_cnt", cnt, 8'hff);
        check("overrun_flag", ovr, 1);
        step(0, 0, 0, 0, 0, 1);
        check("clr_cnt", cnt, 0);
        check("clr_flag", ovr, 0);
        rd(2);

        a0 = acks;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 5, 0);
        step(0, 0, 0, 0, 0, 0);
        check("level_one_ack", acks - a0, 1);
        rd(5);
        check("level_second_ack", acks - a0, 2);

        step(1, 3, 32'h99, 0, 0, 1);
        check("drop_beats_clr", cnt, 1);
        step(0, 0, 0, 0, 0, 1);

        step(1, 1, 32'h55, 1, 31, 0);
        check("release_cycle_drop", cnt, 1);
        check("release_ready", ready, 0);
        step(1, 1, 32'h55, 0, 0, 0);
        spi(31, 32'h3);
        rd(1);
        rd(31);

        step_b(1, 5, 16'hBEEF, 0, 0);
        step_b(1, 7, 16'h0001, 0, 0);
        check("b_ready_locked", ready_b, 1);
        qb.push_back(16'hBEEF);
        step_b(0, 0, 0, 1, 5);
        step_b(0, 0, 0, 0, 0);
        check("b_ready_hold", ready_b, 1);
        qb.push_back(16'h0001);
        step_b(0, 0, 0, 1, 7);
        check("b_ready_release", ready_b, 0);
        step_b(0, 0, 0, 0, 0);

        repeat (5) @(posedge clk);
        #1;
        check("pending_a", q.size(), 0);
        check("pending_b", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
